// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way set-associative data cache: FSM encoding,
// memory-direction encodings and helpers that derive address-field widths.
package dcache_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MISS      = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_REFILL_OK = 3'd4;

  localparam logic MEM_WR_REFILL    = 1'b0;
  localparam logic MEM_WR_WRITEBACK = 1'b1;

  function automatic int calc_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - $clog2(sets) - $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: tag/valid/dirty/data arrays with asynchronous lookup and
// victim read ports, a whole-line fill port and a byte-merging word write port.
module dcache_way_store
  import dcache_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [calc_idx_w(SETS)-1:0]    lk_idx_i,
  output logic                           lk_valid_o,
  output logic [TAG_W-1:0]               lk_tag_o,
  output logic [LINE_W-1:0]              lk_line_o,
  input  logic [calc_idx_w(SETS)-1:0]    vc_idx_i,
  output logic                           vc_valid_o,
  output logic                           vc_dirty_o,
  output logic [TAG_W-1:0]               vc_tag_o,
  output logic [LINE_W-1:0]              vc_line_o,
  input  logic                           fill_en_i,
  input  logic [calc_idx_w(SETS)-1:0]    fill_idx_i,
  input  logic [TAG_W-1:0]               fill_tag_i,
  input  logic [LINE_W-1:0]              fill_line_i,
  input  logic                           wr_en_i,
  input  logic [calc_idx_w(SETS)-1:0]    wr_idx_i,
  input  logic [calc_off_w(LINE_W)-3:0]  wr_word_i,
  input  logic [31:0]                    wr_data_i,
  input  logic [3:0]                     wr_be_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [31:0]       old_word;
  logic [31:0]       merged_word;

  assign lk_valid_o = valid_q[lk_idx_i];
  assign lk_tag_o   = tag_q[lk_idx_i];
  assign lk_line_o  = data_q[lk_idx_i];

  assign vc_valid_o = valid_q[vc_idx_i];
  assign vc_dirty_o = dirty_q[vc_idx_i];
  assign vc_tag_o   = tag_q[vc_idx_i];
  assign vc_line_o  = data_q[vc_idx_i];

  assign old_word = data_q[wr_idx_i][{wr_word_i, 5'd0} +: 32];

  always_comb begin
    merged_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wr_be_i[b]) merged_word[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left without reset; valid gates them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][{wr_word_i, 5'd0} +: 32] <= merged_word;
    end
  end

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate D-cache with per-set LRU,
// byte-enabled writes and a saturating miss counter.
module dcache_2way_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic [3:0]        p1_be_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = calc_off_w(LINE_W);
  localparam int IDX_W  = calc_idx_w(SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINE_W, SETS);
  localparam int WORD_W = OFF_W - 2;

  // Memory handshake: mem_enable_o rises with the request and stays high, with
  // mem_addr_o/mem_data_o frozen, until mem_ack_i is sampled at a clock edge.

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;
  logic              unused_addr_bits;

  assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign req_word         = p1_addr_i[2 +: WORD_W];
  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign unused_addr_bits = ^p1_addr_i[1:0];

  logic [2:0]       state_q, state_d;
  logic             vic_way_q;
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [SETS-1:0]  lru_q;

  logic [1:0]        lk_valid;
  logic [TAG_W-1:0]  lk_tag  [2];
  logic [LINE_W-1:0] lk_line [2];
  logic [1:0]        vc_valid;
  logic [1:0]        vc_dirty;
  logic [TAG_W-1:0]  vc_tag  [2];
  logic [LINE_W-1:0] vc_line [2];
  logic [1:0]        hit_way;
  logic [1:0]        fill_en;
  logic [1:0]        wr_en;

  logic              hit;
  logic              hit_sel;
  logic              hit_ok;
  logic              vic_sel;
  logic              refill_done;
  logic [LINE_W-1:0] hit_line;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign hit_way[w] = req & lk_valid[w] & (lk_tag[w] == req_tag);
    assign fill_en[w] = refill_done & (vic_way_q == w[0]);
    assign wr_en[w]   = hit_ok & p1_MemWrite_i & hit_way[w];

    dcache_way_store #(
      .LINE_W (LINE_W),
      .SETS   (SETS),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .lk_idx_i    (req_idx),
      .lk_valid_o  (lk_valid[w]),
      .lk_tag_o    (lk_tag[w]),
      .lk_line_o   (lk_line[w]),
      .vc_idx_i    (req_idx_q),
      .vc_valid_o  (vc_valid[w]),
      .vc_dirty_o  (vc_dirty[w]),
      .vc_tag_o    (vc_tag[w]),
      .vc_line_o   (vc_line[w]),
      .fill_en_i   (fill_en[w]),
      .fill_idx_i  (req_idx_q),
      .fill_tag_i  (req_tag_q),
      .fill_line_i (mem_data_i),
      .wr_en_i     (wr_en[w]),
      .wr_idx_i    (req_idx),
      .wr_word_i   (req_word),
      .wr_data_i   (p1_data_i),
      .wr_be_i     (p1_be_i)
    );
  end

  assign hit         = |hit_way;
  assign hit_sel     = hit_way[1];
  assign hit_line    = hit_sel ? lk_line[1] : lk_line[0];
  assign p1_data_o   = hit ? hit_line[{req_word, 5'd0} +: 32] : 32'd0;
  assign p1_stall_o  = req & ~hit;
  // Hits only update state while no line transfer is using the arrays.
  assign hit_ok      = (state_q == S_IDLE) | (state_q == S_REFILL_OK);
  assign refill_done = (state_q == S_REFILL) & mem_ack_i;
  assign vic_sel     = ~lk_valid[0] ? 1'b0 : (~lk_valid[1] ? 1'b1 : lru_q[req_idx]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req && !hit) state_d = S_MISS;
      S_MISS:      state_d = (vc_valid[vic_way_q] && vc_dirty[vic_way_q]) ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (mem_ack_i) state_d = S_REFILL;
      S_REFILL:    if (mem_ack_i) state_d = S_REFILL_OK;
      S_REFILL_OK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      vic_way_q  <= 1'b0;
      req_tag_q  <= '0;
      req_idx_q  <= '0;
      miss_cnt_q <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req && !hit) begin
        vic_way_q <= vic_sel;
        req_tag_q <= req_tag;
        req_idx_q <= req_idx;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      // lru_q holds the way to evict next in each set.
      if (refill_done) lru_q[req_idx_q] <= ~vic_way_q;
      else if (hit_ok && hit) lru_q[req_idx] <= ~hit_sel;
    end
  end

  assign mem_enable_o = (state_q == S_WRITEBACK) | (state_q == S_REFILL);
  assign mem_write_o  = (state_q == S_WRITEBACK) ? MEM_WR_WRITEBACK : MEM_WR_REFILL;
  assign mem_addr_o   = {(state_q == S_WRITEBACK) ? vc_tag[vic_way_q] : req_tag_q,
                         req_idx_q, {OFF_W{1'b0}}};
  assign mem_data_o   = vc_line[vic_way_q];
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_2way_top.sv
// Bench for dcache_2way_top: a line memory responder with programmable ack
// latency, a CPU-visible reference image and a read-data expected queue.
module tb_dcache_2way_top;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int SETS   = 16;
  localparam int CNT_W  = 4;

  logic              clk_i;
  logic              rst_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [31:0]       p1_data_i;
  logic [3:0]        p1_be_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic              mem_ack_i;
  logic [CNT_W-1:0]  miss_cnt_o;

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;
  int wait_cnt = 0;

  logic [31:0]       exp_q[$];
  logic [31:0]       xfer_addr_q[$];
  logic              xfer_wr_q[$];
  logic [LINE_W-1:0] xfer_data_q[$];
  logic [LINE_W-1:0] mem_model [1024];
  logic [LINE_W-1:0] ref_line  [1024];

  dcache_2way_top #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .SETS   (SETS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_be_i       (p1_be_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_ack_i     (mem_ack_i),
    .miss_cnt_o    (miss_cnt_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int lidx(input logic [31:0] a);
    return int'(a[14:5]);
  endfunction

  // line memory responder
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_enable_o && !mem_ack_i) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack_i = 1'b1;
          xfer_addr_q.push_back(mem_addr_o);
          xfer_wr_q.push_back(mem_write_o);
          if (mem_write_o) begin
            mem_model[lidx(mem_addr_o)] = mem_data_o;
            xfer_data_q.push_back(mem_data_o);
          end else begin
            mem_data_i = mem_model[lidx(mem_addr_o)];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // driver tasks
  task automatic clear_xfers();
    xfer_addr_q.delete();
    xfer_wr_q.delete();
    xfer_data_q.delete();
  endtask

  task automatic do_reset();
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_line[i] = mem_model[i];
    clear_xfers();
  endtask

  task automatic cpu_issue(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] be);
    int l;
    int wd;
    @(negedge clk_i);
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_be_i       = be;
    p1_MemWrite_i = wr;
    p1_MemRead_i  = !wr;
    l  = lidx(addr);
    wd = int'(addr[4:2]);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_line[l][wd*32 + b*8 +: 8] = wdata[b*8 +: 8];
    end else begin
      exp_q.push_back(ref_line[l][wd*32 +: 32]);
    end
  endtask

  task automatic cpu_complete(output int stall_cycles);
    logic [31:0] exp;
    stall_cycles = 0;
    #1;
    while (p1_stall_o && stall_cycles < 200) begin
      @(negedge clk_i);
      #1;
      stall_cycles++;
    end
    if (p1_stall_o) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout addr=%h stall still high after %0d cycles", p1_addr_i, stall_cycles);
      if (!p1_MemWrite_i && exp_q.size() > 0) exp = exp_q.pop_front();
    end else if (p1_MemRead_i && !p1_MemWrite_i) begin
      exp = exp_q.pop_front();
      checks++;
      if (p1_data_o !== exp) begin
        errors++;
        $display("FAIL read_data addr=%h got=%h exp=%h", p1_addr_i, p1_data_o, exp);
      end
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output int sc);
    cpu_issue(addr, 1'b0, 32'd0, 4'd0);
    cpu_complete(sc);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] be, output int sc);
    cpu_issue(addr, 1'b1, d, be);
    cpu_complete(sc);
  endtask

  // scenarios
  task automatic test_reset();
    rst_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_be_i = '0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    for (int i = 0; i < 1024; i++)
      for (int w = 0; w < 8; w++) mem_model[i][w*32 +: 32] = $urandom();
    mem_model[2][31:0]  = 32'hDEADBEEF;
    mem_model[2][63:32] = 32'hAAAAAAAA;
    #1;
    checks++;
    if (miss_cnt_o !== '0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs cnt=%0d en=%b wr=%b exp 0/0/0", miss_cnt_o, mem_enable_o, mem_write_o);
    end
    do_reset();
    #1;
    checks++;
    if (p1_stall_o !== 1'b0 || p1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL idle_outputs stall=%b data=%h exp 0/0", p1_stall_o, p1_data_o);
    end
  endtask

  task automatic test_cold_read();
    int sc;
    ack_delay = 3;
    clear_xfers();
    cpu_issue(32'h40, 1'b0, 32'd0, 4'd0);
    #1;
    checks++;
    if (p1_stall_o !== 1'b1 || p1_data_o !== 32'd0) begin
      errors++;
      $display("FAIL cold_miss stall=%b data=%h exp 1/0", p1_stall_o, p1_data_o);
    end
    cpu_complete(sc);
    checks++;
    if (xfer_addr_q.size() != 1 || xfer_addr_q[0] !== 32'h40 || xfer_wr_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL cold_xfer n=%0d exp one refill of 00000040", xfer_addr_q.size());
    end
    checks++;
    if (miss_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL cold_cnt got=%0d exp=1", miss_cnt_o);
    end
    ack_delay = 1;
  endtask

  task automatic test_two_way();
    int sc;
    do_reset();
    cpu_read(32'h040, sc);
    cpu_read(32'h240, sc);
    cpu_read(32'h040, sc);
    checks++;
    if (sc != 0) begin
      errors++;
      $display("FAIL two_way_hit stall_cycles=%0d exp 0", sc);
    end
    checks++;
    if (xfer_addr_q.size() != 2 || xfer_wr_q[0] !== 1'b0 || xfer_wr_q[1] !== 1'b0) begin
      errors++;
      $display("FAIL two_way_xfers n=%0d exp two refills", xfer_addr_q.size());
    end
    checks++;
    if (miss_cnt_o !== 4'd2) begin
      errors++;
      $display("FAIL two_way_cnt got=%0d exp=2", miss_cnt_o);
    end
  endtask

  task automatic test_byte_write();
    int sc;
    cpu_write(32'h044, 32'h12345678, 4'b0011, sc);
    checks++;
    if (sc != 0) begin
      errors++;
      $display("FAIL write_hit_stall stall_cycles=%0d exp 0", sc);
    end
    cpu_read(32'h044, sc);
  endtask

  task automatic test_writeback();
    int sc;
    clear_xfers();
    cpu_read(32'h240, sc);
    checks++;
    if (sc != 0) begin
      errors++;
      $display("FAIL wb_pre_hit stall_cycles=%0d exp 0", sc);
    end
    cpu_read(32'h440, sc);
    checks++;
    if (xfer_addr_q.size() != 2 || xfer_addr_q[0] !== 32'h40 || xfer_wr_q[0] !== 1'b1 ||
        xfer_addr_q[1] !== 32'h440 || xfer_wr_q[1] !== 1'b0) begin
      errors++;
      $display("FAIL wb_sequence n=%0d exp writeback 00000040 then refill 00000440", xfer_addr_q.size());
    end
    checks++;
    if (xfer_data_q.size() != 1 || xfer_data_q[0][63:32] !== 32'hAAAA5678) begin
      errors++;
      $display("FAIL wb_data n=%0d word1 exp aaaa5678", xfer_data_q.size());
    end
    cpu_read(32'h240, sc);
    checks++;
    if (sc != 0) begin
      errors++;
      $display("FAIL wb_post_hit stall_cycles=%0d exp 0", sc);
    end
    checks++;
    if (miss_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL wb_cnt got=%0d exp=3", miss_cnt_o);
    end
  endtask

  task automatic test_ack_hold();
    int sc;
    int n;
    int held;
    int bad;
    ack_delay = 10;
    cpu_issue(32'h640, 1'b0, 32'd0, 4'd0);
    n = 0;
    do begin
      @(negedge clk_i);
      #2;
      n++;
    end while (!mem_enable_o && n < 50);
    held = 0;
    bad  = 0;
    while (!mem_ack_i && held < 50) begin
      if (!mem_enable_o || mem_write_o || mem_addr_o !== 32'h640 || !p1_stall_o) bad++;
      held++;
      @(negedge clk_i);
      #2;
    end
    checks++;
    if (bad != 0 || held != 10) begin
      errors++;
      $display("FAIL ack_hold unstable=%0d held=%0d exp 0 and 10", bad, held);
    end
    @(negedge clk_i);
    #2;
    checks++;
    if (mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_release en=%b exp 0", mem_enable_o);
    end
    cpu_complete(sc);
    ack_delay = 1;
  endtask

  task automatic test_reset_mid_wb();
    int sc;
    int n;
    cpu_write(32'h244, 32'hCAFEF00D, 4'b1111, sc);
    cpu_read(32'h640, sc);
    ack_delay = 1000;
    cpu_issue(32'h840, 1'b0, 32'd0, 4'd0);
    n = 0;
    do begin
      @(negedge clk_i);
      #2;
      n++;
    end while (!(mem_enable_o && mem_write_o) && n < 50);
    checks++;
    if (!(mem_enable_o && mem_write_o) || mem_addr_o !== 32'h240) begin
      errors++;
      $display("FAIL wb_start en=%b wr=%b addr=%h exp 1/1/00000240", mem_enable_o, mem_write_o, mem_addr_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || miss_cnt_o !== '0) begin
      errors++;
      $display("FAIL async_reset en=%b wr=%b cnt=%0d exp 0/0/0", mem_enable_o, mem_write_o, miss_cnt_o);
    end
    do_reset();
    ack_delay = 1;
    cpu_read(32'h240, sc);
    checks++;
    if (sc == 0 || miss_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_miss stall_cycles=%0d cnt=%0d exp >0 and 1", sc, miss_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int sc;
    logic [CNT_W-1:0] exp_cnt;
    logic [31:0] a;
    do_reset();
    for (int t = 0; t < 18; t++) begin
      a = (32'(t) << 9) | (32'd3 << 5) | (32'($urandom_range(0, 7)) << 2);
      cpu_read(a, sc);
      exp_cnt = (t + 1 > 15) ? 4'd15 : 4'(t + 1);
      checks++;
      if (miss_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL miss_count step=%0d got=%0d exp=%0d", t, miss_cnt_o, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'd6 << 5) | (32'($urandom_range(0, 7)) << 2);
      ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1)
        cpu_write(a, $urandom(), 4'($urandom_range(0, 15)), sc);
      else
        cpu_read(a, sc);
    end
    ack_delay = 1;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_two_way();
    test_byte_write();
    test_writeback();
    test_ack_hold();
    test_reset_mid_wb();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU data port (p1_*) and the line-wide data memory (mem_*). It succeeds the direct-mapped L1 D-cache with configurable set count and line width, per-set LRU replacement, per-byte write enables and a saturating miss counter. Tag, valid, dirty, data and LRU state are held in internal register arrays with asynchronous read.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, line width in bits (power of two, ≥64)
SETS, 16, number of sets (power of two, ≥2)
CNT_W, 16, miss counter width
Derived: OFF_W=log2(LINE_W/8), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
p1_data_i  in  32  write data
p1_be_i  in  4  byte enables for writes
p1_MemRead_i  in  1  read request
p1_MemWrite_i  in  1  write request; wins if both are asserted
p1_data_o  out  32  read data
p1_stall_o  out  1  CPU must hold its request while high
mem_addr_o  out  ADDR_W  line address, low OFF_W bits zero
mem_data_o  out  LINE_W  write-back line
mem_data_i  in  LINE_W  refill line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill
mem_ack_i  in  1  transfer done
miss_cnt_o  out  CNT_W  saturating miss count

Behaviour:
- Address split: tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], word=[OFF_W-1:2].
- Hit: req & valid[w] & tag match in either way; dirty does not affect hit. p1_stall_o = req & ~hit, combinational.
- Read hit: p1_data_o = selected 32-bit word, combinational, zero wait states. p1_data_o=0 when no hit.
- Write hit at posedge:
  - bytes with p1_be_i[b]=1 are replaced; other bytes are kept.
  - dirty[w] is set.
- Any hit at posedge: lru[set] is set to the way not hit.
- Victim selection: invalid way0, else invalid way1, else lru[set]. The victim is latched on leaving IDLE.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_OK.
  - IDLE: on req & ~hit, go to MISS and increment miss_cnt_o (saturates at all ones).
  - MISS: if the victim is valid & dirty, go to WRITEBACK with enable=1, write=1, addr={victim tag, index, 0}, mem_data_o=victim line. Otherwise go to REFILL with enable=1, write=0, addr={req tag, index, 0}.
  - WRITEBACK: hold outputs until mem_ack_i. On ack go to REFILL; mem_enable_o stays 1, mem_write_o becomes 0 and addr switches to the request line.
  - REFILL: hold until mem_ack_i. On that edge write mem_data_i into the victim, set valid=1, dirty=0, tag=req tag, lru[set]=other way. Then mem_enable_o becomes 0 and the FSM goes to REFILL_OK.
  - REFILL_OK: one idle cycle, then IDLE. The held request now hits; a write completes as a write hit.
- Handshake: mem_enable_o stays high continuously until ack is sampled. mem_ack_i is ignored outside WRITEBACK/REFILL. mem_addr_o and mem_data_o are stable while enable is high.
- Request dropped mid-miss: the transaction completes and the line is installed. The FSM returns to IDLE with no CPU write.
- Reset (asynchronous, any state):
  - state=IDLE; all valid, dirty and lru cleared; miss_cnt_o=0.
  - mem_enable_o=0, mem_write_o=0 immediately.
  - A write-back in flight is abandoned and its data is lost.
- Data array contents are not reset. With no request, the cache performs no state change.

Decomposition:
- Package dcache_pkg: FSM state encoding, derived-width localparam functions (OFF_W/IDX_W/TAG_W), mem_write encodings.
- One natural sub-module, dcache_way_store, instantiated twice. It holds the tag/valid/dirty/data arrays with async read, line write and byte-merge write port.
- LRU bits and the FSM stay in the top.

Test Plan:
1. Cold read 0x0000_0040 with memory word0=0xDEADBEEF, ack after 3 cycles -> stall high; mem_addr_o=0x40, mem_write_o=0; after REFILL_OK, stall low, p1_data_o=0xDEADBEEF, miss_cnt_o=1.
2. Read 0x040, then 0x240 (same set 2), then 0x040 -> two refills with no write-back; third access hits with no stall; miss_cnt_o=2.
3. Write 0x044, be=4'b0011, data=0x12345678, over stored 0xAAAAAAAA -> no stall; subsequent read 0x044 returns 0xAAAA5678.
4. After test 3: read 0x240 (hit), then read 0x440 -> write-back with mem_addr_o=0x040, mem_write_o=1, word1 of mem_data_o=0xAAAA5678; then refill of 0x440; 0x240 still hits.
5. Hold mem_ack_i low 10 cycles during REFILL -> mem_enable_o, mem_addr_o and stall all constant high/stable; the single ack ends the transfer, and enable falls the next cycle.
6. Assert rst_i low mid-WRITEBACK -> mem_enable_o=0 and miss_cnt_o=0 without a clock edge; a later read of 0x240 misses.
